// File: rtl/demux_sample_ctrl.sv
// Capture sequencer behind the 16->32 channel demux: paces captures with a divider,
// masks disabled channel groups, counts samples and presents them on a valid/ready stream.
module demux_sample_ctrl #(
  parameter int DIV_WIDTH = 24,
  parameter int CNT_WIDTH = 20
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 cfg_demux,
  input  logic [DIV_WIDTH-1:0] cfg_divider,
  input  logic [CNT_WIDTH-1:0] cfg_count,
  input  logic [3:0]           cfg_group_dis,
  input  logic                 arm,
  input  logic                 abort,
  input  logic [31:0]          indata,
  input  logic [31:0]          demux_data,
  output logic [31:0]          out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 running,
  output logic                 done,
  output logic                 overrun
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [DIV_WIDTH-1:0] div_cnt_q;
  logic [CNT_WIDTH-1:0] smp_cnt_q;
  logic                 sh_demux_q;
  logic [DIV_WIDTH-1:0] sh_div_q;
  logic [CNT_WIDTH-1:0] sh_cnt_q;
  logic [3:0]           sh_gd_q;
  logic [31:0]          out_data_q;
  logic                 out_valid_q;
  logic                 overrun_q;

  logic [31:0]          cap_word_d;
  logic [CNT_WIDTH-1:0] smp_cnt_d;
  logic                 accept;

  always_comb begin
    cap_word_d = sh_demux_q ? demux_data : indata;
    for (int g = 0; g < 4; g++) begin
      if (sh_gd_q[g]) cap_word_d[8*g +: 8] = 8'h00;
    end
  end

  // Wraps to zero after 2^CNT_WIDTH samples, which is how a zero count means "full range".
  assign smp_cnt_d = smp_cnt_q + CNT_WIDTH'(1);
  assign accept    = out_valid_q & out_ready;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      div_cnt_q   <= '0;
      smp_cnt_q   <= '0;
      sh_demux_q  <= 1'b0;
      sh_div_q    <= '0;
      sh_cnt_q    <= '0;
      sh_gd_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (abort) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            state_q     <= S_RUN;
            div_cnt_q   <= cfg_divider;
            smp_cnt_q   <= '0;
            overrun_q   <= 1'b0;
            out_valid_q <= 1'b0;
            sh_demux_q  <= cfg_demux;
            sh_div_q    <= cfg_divider;
            sh_cnt_q    <= cfg_count;
            sh_gd_q     <= cfg_group_dis;
          end else if (accept) begin
            out_valid_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (div_cnt_q == '0) begin
            div_cnt_q <= sh_div_q;
            // A stalled sample is kept; the new word is dropped but still counted.
            if (out_valid_q && !out_ready) begin
              overrun_q <= 1'b1;
            end else begin
              out_data_q  <= cap_word_d;
              out_valid_q <= 1'b1;
            end
            smp_cnt_q <= smp_cnt_d;
            if (smp_cnt_d == sh_cnt_q) state_q <= S_DONE;
          end else begin
            div_cnt_q <= div_cnt_q - DIV_WIDTH'(1);
            if (accept) out_valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign running   = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_demux_sample_ctrl.sv
// Directed and randomized bench for demux_sample_ctrl, checked against a schedule-based model.
module tb_demux_sample_ctrl;

  localparam int DW = 24;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          cfg_demux = 1'b0;
  logic [DW-1:0] cfg_divider = '0;
  logic [CW-1:0] cfg_count = '0;
  logic [3:0]    cfg_group_dis = '0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic [31:0]   indata = '0;
  logic [31:0]   demux_data = '0;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          running;
  logic          done;
  logic          overrun;

  int checks = 0;
  int failures = 0;

  demux_sample_ctrl #(.DIV_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset_n(reset_n), .cfg_demux(cfg_demux), .cfg_divider(cfg_divider),
    .cfg_count(cfg_count), .cfg_group_dis(cfg_group_dis), .arm(arm), .abort(abort),
    .indata(indata), .demux_data(demux_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .running(running), .done(done), .overrun(overrun)
  );

  always #5 clock = ~clock;

  // Model: a run is a schedule of capture instants t0 + k*(N+1), not a counter.
  longint      t = 0;
  longint      m_next = 0;
  int          m_left = 0;
  int          m_div = 0;
  bit          m_active = 0, m_done = 0, m_valid = 0, m_overrun = 0, m_demux = 0;
  logic [3:0]  m_gd = '0;
  logic [31:0] m_data = '0;

  function automatic logic [31:0] pick(input bit dmx, input logic [3:0] gd,
                                       input logic [31:0] dd, input logic [31:0] id);
    logic [31:0] w;
    w = dmx ? dd : id;
    for (int g = 0; g < 4; g++) if (gd[g]) w[8*g +: 8] = 8'h00;
    return w;
  endfunction

  task automatic model_update();
    if (!reset_n) begin
      m_active = 0; m_done = 0; m_valid = 0; m_overrun = 0; m_data = '0;
    end else if (abort) begin
      m_active = 0; m_done = 0; m_valid = 0;
    end else if (!m_active && arm) begin
      m_active = 1; m_done = 0; m_valid = 0; m_overrun = 0;
      m_div = int'(cfg_divider);
      m_next = t + 1 + m_div;
      m_left = (cfg_count == 0) ? (1 << CW) : int'(cfg_count);
      m_demux = cfg_demux;
      m_gd = cfg_group_dis;
    end else if (m_active && t == m_next) begin
      if (m_valid && !out_ready) m_overrun = 1;
      else begin
        m_data = pick(m_demux, m_gd, demux_data, indata);
        m_valid = 1;
      end
      m_left--;
      m_next = m_next + m_div + 1;
      if (m_left == 0) begin m_active = 0; m_done = 1; end
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_update();
    #1;
    chk("out_data", out_data, m_data);
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("running", 32'(running), 32'(m_active));
    chk("done", 32'(done), 32'(m_done));
    chk("overrun", 32'(overrun), 32'(m_overrun));
    t++;
  endtask

  int n_valid;
  logic [31:0] first_word;

  initial begin
    // Reset dominates a held arm
    reset_n = 1'b0; arm = 1'b1; abort = 1'b0;
    repeat (3) step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    reset_n = 1'b1; arm = 1'b0;
    repeat (3) step();
    chk("idle_running", 32'(running), 32'd0);

    // Plain mode, divider 3, four samples
    cfg_demux = 1'b0; cfg_divider = 24'd3; cfg_count = 4'd4; cfg_group_dis = 4'b0000;
    out_ready = 1'b1; indata = 32'hA5A5_0001;
    arm = 1'b1; step(); arm = 1'b0;
    n_valid = 0;
    repeat (24) begin
      indata = indata + 32'd1;
      step();
      if (out_valid) n_valid++;
    end
    chk("t2_samples", 32'(n_valid), 32'd4);
    chk("t2_done", 32'(done), 32'd1);

    // Demux mode with groups 1 and 3 masked
    cfg_demux = 1'b1; cfg_divider = 24'd0; cfg_count = 4'd0; cfg_group_dis = 4'b1010;
    demux_data = 32'hFFFF_FFFF; indata = 32'h1234_5678;
    arm = 1'b1; step(); arm = 1'b0;
    step(); step();
    chk("t3_word", out_data, 32'h00FF_00FF);
    step();
    chk("t3_word2", out_data, 32'h00FF_00FF);
    repeat (20) step();

    // Backpressure: first sample held, later ones dropped
    cfg_demux = 1'b0; cfg_divider = 24'd0; cfg_count = 4'd8; cfg_group_dis = 4'b0000;
    out_ready = 1'b0; indata = 32'h1000_0000;
    arm = 1'b1; step(); arm = 1'b0;
    indata = indata + 32'd1;
    first_word = indata;
    repeat (10) begin
      step();
      indata = indata + 32'd1;
    end
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_overrun", 32'(overrun), 32'd1);
    chk("t4_held", out_data, first_word);
    chk("t4_pending", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    chk("t4_drained", 32'(out_valid), 32'd0);
    step();

    // Abort at sample 2 of 10, then a clean re-run
    cfg_divider = 24'd1; cfg_count = 4'd10; out_ready = 1'b1;
    arm = 1'b1; step(); arm = 1'b0;
    for (int i = 0; i < 12 && m_left > 8; i++) begin
      indata = $urandom; step();
    end
    chk("t5_reached_s2", 32'(m_left), 32'd8);
    abort = 1'b1; step(); abort = 1'b0;
    chk("t5_abort_run", 32'(running), 32'd0);
    chk("t5_abort_valid", 32'(out_valid), 32'd0);
    arm = 1'b1; step(); arm = 1'b0;
    n_valid = 0;
    repeat (30) begin
      indata = $urandom; step();
      if (out_valid) n_valid++;
    end
    chk("t5_samples", 32'(n_valid), 32'd10);
    chk("t5_done", 32'(done), 32'd1);

    // Zero count means the full 2^CW samples
    cfg_divider = 24'd0; cfg_count = 4'd0;
    arm = 1'b1; step(); arm = 1'b0;
    n_valid = 0;
    repeat (25) begin
      indata = $urandom; step();
      if (out_valid) n_valid++;
    end
    chk("t6_samples", 32'(n_valid), 32'd16);
    chk("t6_done", 32'(done), 32'd1);

    // Random traffic, config churn during runs, stray arms, aborts and resets
    repeat (1500) begin
      indata        = $urandom;
      demux_data    = $urandom;
      cfg_demux     = 1'($urandom_range(0, 1));
      cfg_divider   = DW'($urandom_range(0, 3));
      cfg_count     = CW'($urandom_range(0, 15));
      cfg_group_dis = 4'($urandom_range(0, 15));
      out_ready     = ($urandom_range(0, 3) != 0);
      arm           = ($urandom_range(0, 9) == 0);
      abort         = ($urandom_range(0, 79) == 0);
      reset_n       = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
